sdram_memtest: RTL

SDRAM_MEMTEST -- requirements
Module: sdram_memtest

---
 rtl/sdram_memtest.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/sdram_memtest.sv
// rtl/sdram_memtest.sv - four-phase SDRAM march test engine
//
// Sweeps the word address range 0..LAST_ADR four times:
//   PH0 write P(a) (both bytes), PH1 read/compare P(a),
//   PH2 write ~P(a)[15:8] to the high byte only, PH3 read/compare
//   {~P(a)[15:8], P(a)[7:0]}, where P(a) = a[16:1] ^ {11'd0, a[21:17]}.
//
// Ports
//   clk_p        clock, rising edge
//   rst_n        asynchronous active-low reset
//   start        single-cycle pulse, starts a test from IDLE or FINISH
//   sdram_ready  SDRAM initialisation complete
//   sdram_stb    transaction strobe (registered, high only in ACCESS)
//   sdram_we     1 = write, 0 = read
//   sdram_sel    byte select, bit1 high byte, bit0 low byte
//   sdram_adr    word address [21:1]
//   sdram_out    write data
//   sdram_dat    read data
//   sdram_ack    transaction acknowledge
//   busy         test running
//   done         test finished, held until the next start
//   pass         valid with done: no mismatch and no timeout
//   timeout      test aborted, ack never arrived
//   err_count    mismatch count, saturating at 8'hFF
//   err_adr      address of the first mismatch
//   err_dat      data read at the first mismatch

module sdram_memtest #(
   parameter logic [20:0] LAST_ADR = 21'h1FFFFF,
   parameter logic [15:0] TIMEOUT  = 16'd4095
) (
   input  logic        clk_p,
   input  logic        rst_n,
   input  logic        start,
   input  logic        sdram_ready,
   output logic        sdram_stb,
   output logic        sdram_we,
   output logic [1:0]  sdram_sel,
   output logic [21:1] sdram_adr,
   output logic [15:0] sdram_out,
   input  logic [15:0] sdram_dat,
   input  logic        sdram_ack,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic        timeout,
   output logic [7:0]  err_count,
   output logic [20:0] err_adr,
   output logic [15:0] err_dat
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAITRDY,
      S_ACCESS,
      S_GAP,
      S_FINISH
   } state_t;

   // Last watchdog value before the abort; the first ACCESS cycle sees 0,
   // so the strobe stays high for exactly TIMEOUT cycles without an ack.
   localparam logic [15:0] WDOG_LAST = TIMEOUT - 16'd1;

   state_t      state;
   state_t      state_nxt;
   logic [1:0]  phase;
   logic [1:0]  phase_nxt;
   logic [20:0] adr;
   logic [20:0] adr_nxt;
   logic [15:0] wdog;
   logic        stb_q;

   logic        clear_status;
   logic        wdog_expired;
   logic        ack_seen;
   logic        phase_is_read;
   logic        mismatch;
   logic [15:0] pat;
   logic [15:0] wr_data;
   logic [15:0] rd_expect;

   // Pattern generation from the current word address
   assign pat           = adr[15:0] ^ {11'd0, adr[20:16]};
   assign phase_is_read = phase[0];
   assign wr_data       = phase[1] ? {~pat[15:8], 8'h00} : pat;
   // PH3 expects the PH0 low byte to survive the high-byte-only write
   assign rd_expect     = phase[1] ? {~pat[15:8], pat[7:0]} : pat;

   // An ack only counts while our strobe is out
   assign ack_seen = (state == S_ACCESS) & stb_q & sdram_ack;
   assign mismatch = ack_seen & phase_is_read & (sdram_dat != rd_expect);

   // ---------------------------------------------------------------
   // FSM state register
   // ---------------------------------------------------------------
   always_ff @(posedge clk_p or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ---------------------------------------------------------------
   // FSM next state and sweep control
   // ---------------------------------------------------------------
   always_comb begin
      state_nxt    = state;
      phase_nxt    = phase;
      adr_nxt      = adr;
      clear_status = 1'b0;
      wdog_expired = 1'b0;

      case (state)
         S_IDLE, S_FINISH: begin
            if (start) begin
               clear_status = 1'b1;
               phase_nxt    = 2'd0;
               adr_nxt      = 21'd0;
               state_nxt    = S_WAITRDY;
            end
         end

         S_WAITRDY: begin
            if (sdram_ready) begin
               state_nxt = S_ACCESS;
            end
         end

         S_ACCESS: begin
            // Ack wins over a watchdog expiry in the same cycle
            if (ack_seen) begin
               state_nxt = S_GAP;
            end else if (wdog == WDOG_LAST) begin
               wdog_expired = 1'b1;
               state_nxt    = S_FINISH;
            end
         end

         S_GAP: begin
            if (adr == LAST_ADR) begin
               adr_nxt = 21'd0;
               if (phase == 2'd3) begin
                  state_nxt = S_FINISH;
               end else begin
                  phase_nxt = phase + 2'd1;
                  state_nxt = S_ACCESS;
               end
            end else begin
               adr_nxt   = adr + 21'd1;
               state_nxt = S_ACCESS;
            end
         end

         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------
   // Datapath, strobe, watchdog and status registers
   // ---------------------------------------------------------------
   always_ff @(posedge clk_p or negedge rst_n) begin
      if (!rst_n) begin
         phase     <= 2'd0;
         adr       <= 21'd0;
         wdog      <= 16'd0;
         stb_q     <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         timeout   <= 1'b0;
         err_count <= 8'd0;
         err_adr   <= 21'd0;
         err_dat   <= 16'd0;
      end else begin
         phase <= phase_nxt;
         adr   <= adr_nxt;
         stb_q <= (state_nxt == S_ACCESS);
         busy  <= (state_nxt == S_WAITRDY) || (state_nxt == S_ACCESS) ||
                  (state_nxt == S_GAP);
         done  <= (state_nxt == S_FINISH);

         // Counts only while staying in ACCESS, so every entry starts at 0
         if ((state == S_ACCESS) && (state_nxt == S_ACCESS)) begin
            wdog <= wdog + 16'd1;
         end else begin
            wdog <= 16'd0;
         end

         if (clear_status) begin
            timeout   <= 1'b0;
            err_count <= 8'd0;
            err_adr   <= 21'd0;
            err_dat   <= 16'd0;
         end else begin
            if (wdog_expired) begin
               timeout <= 1'b1;
            end
            if (mismatch) begin
               // err_count is cleared at start, so zero marks the first miss
               if (err_count == 8'd0) begin
                  err_adr <= adr;
                  err_dat <= sdram_dat;
               end
               if (err_count != 8'hFF) begin
                  err_count <= err_count + 8'd1;
               end
            end
         end
      end
   end

   // ---------------------------------------------------------------
   // Bus outputs: all qualified by the strobe so they read 0 when idle
   // and hold steady for the whole access.
   // ---------------------------------------------------------------
   assign sdram_stb = stb_q;
   assign sdram_we  = stb_q & ~phase_is_read;
   assign sdram_sel = stb_q ? ((phase == 2'd2) ? 2'b10 : 2'b11) : 2'b00;
   assign sdram_adr = stb_q ? adr : 21'd0;
   assign sdram_out = (stb_q & ~phase_is_read) ? wr_data : 16'd0;

   assign pass = done & (err_count == 8'd0) & ~timeout;

endmodule
